// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Purpose  : Measures the high and low durations of an asynchronous PWM
//             input in clk cycles. Each complete period (rising edge to
//             rising edge) is published as a (high_count, low_count) pair
//             through a sticky valid/ack handshake.
//  Ports    :
//    clk         in   system clock, all logic on posedge
//    rst         in   synchronous active-high reset
//    pwm_in      in   asynchronous PWM input
//    ack         in   one-cycle pulse, clears valid and overrun
//    high_count  out  [WIDTH] cycles high in last complete period
//    low_count   out  [WIDTH] cycles low in last complete period
//    valid       out  sticky, new pair available
//    overrun     out  sticky, a pair was overwritten while valid = 1
//    sat         out  published pair contains a saturated count
//    busy        out  measurement in progress (HIGH or LOW state)
//  Options  : define PWM_CAPTURE_GLITCH_FILTER_EN to insert a FILTER_LEN
//             sample glitch filter after the synchronizer.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             ack,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] low_count,
  output logic             valid,
  output logic             overrun,
  output logic             sat,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FILTER_EXTRA = FILTER_LEN - 1;
`else
  // Filter absent: FILTER_LEN contributes no delay.
  localparam int FILTER_EXTRA = FILTER_LEN * 0;
`endif

  // Cycles after reset before the edge detector sees a real input level.
  // Up to then the cleared synchronizer may manufacture a rising edge from
  // an input that was already high; such an edge is not a period start.
  localparam int SETTLE   = SYNC_STAGES + 1 + FILTER_EXTRA;
  localparam int SETTLE_W = $clog2(SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizer
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Level s and its one-cycle delayed copy s_d
  // --------------------------------------------------------------------------
  logic s;
  logic s_d;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  logic [FCNT_W-1:0] fcnt;
  logic              differ;

  // s_d doubles as the filter's current level. The FILTER_LEN-th differing
  // sample switches s combinationally, so every edge is delayed by exactly
  // FILTER_LEN-1 cycles and durations are preserved.
  assign differ = (sync_lvl != s_d);
  assign s      = (differ && (fcnt == FCNT_LAST)) ? sync_lvl : s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= '0;
    end else if (differ && (fcnt != FCNT_LAST)) begin
      fcnt <= fcnt + 1'b1;
    end else begin
      fcnt <= '0;
    end
  end
`else
  assign s = sync_lvl;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  logic rise;
  logic fall;

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // --------------------------------------------------------------------------
  // Post-reset settle counter
  // --------------------------------------------------------------------------
  logic [SETTLE_W-1:0] settle_cnt;
  logic                settled;

  assign settled = (settle_cnt == SETTLE_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Measurement FSM
  // --------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   load_h;
  logic   inc_h;
  logic   load_l;
  logic   inc_l;
  logic   publish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_h  = 1'b0;
    inc_h   = 1'b0;
    load_l  = 1'b0;
    inc_l   = 1'b0;
    publish = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise && settled) begin
          state_d = ST_HIGH;
          load_h  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          load_l  = 1'b1;
        end else if (s) begin
          inc_h = 1'b1;
        end
      end
      ST_LOW: begin
        // Rising edge closes the period and opens the next one in the
        // same cycle, so consecutive periods have no gap.
        if (rise) begin
          state_d = ST_HIGH;
          load_h  = 1'b1;
          publish = 1'b1;
        end else if (!s) begin
          inc_l = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // --------------------------------------------------------------------------
  // Duration counters, saturating at CNT_MAX
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] lcnt;
  logic             hsat;
  logic             lsat;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      hsat <= 1'b0;
    end else if (load_h) begin
      hcnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      hsat <= 1'b0;
    end else if (inc_h) begin
      if (hcnt == CNT_MAX) begin
        hsat <= 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt <= '0;
      lsat <= 1'b0;
    end else if (load_l) begin
      lcnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      lsat <= 1'b0;
    end else if (inc_l) begin
      if (lcnt == CNT_MAX) begin
        lsat <= 1'b1;
      end else begin
        lcnt <= lcnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Published result and handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      high_count <= '0;
      low_count  <= '0;
      sat        <= 1'b0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else if (publish) begin
      high_count <= hcnt;
      low_count  <= lcnt;
      sat        <= hsat | lsat;
      valid      <= 1'b1;
      // A coincident ack consumes the previous pair, so nothing is lost.
      overrun    <= ack ? 1'b0 : (overrun | valid);
    end else if (ack) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_capture
//  Purpose  : Directed self-checking bench for pwm_capture. Instance dut_a
//             uses WIDTH = 16, instance dut_b uses WIDTH = 4 for saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

  // Calls from the rising-edge stimulus cycle to the call after which the
  // published pair is visible.
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int PUB   = 5;
  localparam int LOW_B = 3;
`else
  localparam int PUB   = 3;
  localparam int LOW_B = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_a = 1'b0;
  logic        ack_a = 1'b0;
  logic        pwm_b = 1'b0;
  logic        ack_b = 1'b0;

  logic [15:0] hc_a;
  logic [15:0] lc_a;
  logic        valid_a;
  logic        overrun_a;
  logic        sat_a;
  logic        busy_a;
  logic [3:0]  hc_b;
  logic [3:0]  lc_b;
  logic        valid_b;
  logic        overrun_b;
  logic        sat_b;
  logic        busy_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(3)) dut_a (
    .clk(clk), .rst(rst), .pwm_in(pwm_a), .ack(ack_a),
    .high_count(hc_a), .low_count(lc_a), .valid(valid_a),
    .overrun(overrun_a), .sat(sat_a), .busy(busy_a)
  );

  pwm_capture #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(3)) dut_b (
    .clk(clk), .rst(rst), .pwm_in(pwm_b), .ack(ack_b),
    .high_count(hc_b), .low_count(lc_b), .valid(valid_b),
    .overrun(overrun_b), .sat(sat_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic p, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_a = p;
      tick();
    end
  endtask

  task automatic run_b(input logic p, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_b = p;
      tick();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset values
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_high_count", 32'(hc_a), 32'd0);
    check("rst_low_count",  32'(lc_a), 32'd0);
    check("rst_valid",      32'(valid_a), 32'd0);
    check("rst_overrun",    32'(overrun_a), 32'd0);
    check("rst_sat",        32'(sat_a), 32'd0);
    check("rst_busy",       32'(busy_a), 32'd0);
    check("rst_valid_b",    32'(valid_b), 32'd0);
    rst = 1'b0;
    run_a(1'b0, 6);

    // ---- periodic 5/3: first rise opens, second rise publishes
    run_a(1'b1, 5);
    run_a(1'b0, 3);
    run_a(1'b1, PUB - 1);
    check("p1_not_yet_valid", 32'(valid_a), 32'd0);
    check("p1_busy",          32'(busy_a), 32'd1);
    run_a(1'b1, 1);
    check("p1_valid", 32'(valid_a), 32'd1);
    check("p1_high",  32'(hc_a), 32'd5);
    check("p1_low",   32'(lc_a), 32'd3);
    check("p1_sat",   32'(sat_a), 32'd0);
    check("p1_ovr",   32'(overrun_a), 32'd0);

    // ---- second pair without ack -> overrun
    run_a(1'b1, 5 - PUB);
    run_a(1'b0, 6);
    run_a(1'b1, PUB);
    check("p2_valid", 32'(valid_a), 32'd1);
    check("p2_ovr",   32'(overrun_a), 32'd1);
    check("p2_high",  32'(hc_a), 32'd5);
    check("p2_low",   32'(lc_a), 32'd6);

    // ---- ack clears valid and overrun
    ack_a = 1'b1;
    run_a(1'b1, 1);
    ack_a = 1'b0;
    check("ack_valid", 32'(valid_a), 32'd0);
    check("ack_ovr",   32'(overrun_a), 32'd0);

    // ---- 6/3 period publishes fresh with no overrun
    run_a(1'b1, 5 - PUB);
    run_a(1'b0, 3);
    run_a(1'b1, PUB);
    check("p3_valid", 32'(valid_a), 32'd1);
    check("p3_ovr",   32'(overrun_a), 32'd0);
    check("p3_high",  32'(hc_a), 32'd6);
    check("p3_low",   32'(lc_a), 32'd3);

    // ---- 7/4 period, ack coincident with publish
    run_a(1'b1, 7 - PUB);
    run_a(1'b0, 4);
    run_a(1'b1, PUB - 1);
    ack_a = 1'b1;
    run_a(1'b1, 1);
    ack_a = 1'b0;
    check("coinc_valid", 32'(valid_a), 32'd1);
    check("coinc_ovr",   32'(overrun_a), 32'd0);
    check("coinc_high",  32'(hc_a), 32'd7);
    check("coinc_low",   32'(lc_a), 32'd4);

    // ---- reset during the high phase of a 10/10 waveform
    run_a(1'b1, 3);
    rst = 1'b1;
    run_a(1'b1, 1);
    rst = 1'b0;
    check("midrst_busy",  32'(busy_a), 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_high",  32'(hc_a), 32'd0);
    check("midrst_low",   32'(lc_a), 32'd0);
    check("midrst_ovr",   32'(overrun_a), 32'd0);
    run_a(1'b1, 5);
    run_a(1'b0, 10);
    run_a(1'b1, 10);
    run_a(1'b0, 10);
    run_a(1'b1, PUB - 1);
    check("postrst_no_partial", 32'(valid_a), 32'd0);
    run_a(1'b1, 1);
    check("postrst_valid", 32'(valid_a), 32'd1);
    check("postrst_high",  32'(hc_a), 32'd10);
    check("postrst_low",   32'(lc_a), 32'd10);

    // ---- 2-cycle low glitch inside a 10-cycle high phase, then low 10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_a(1'b0, 6);
    run_a(1'b1, 4);
    run_a(1'b0, 2);
    run_a(1'b1, 3);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    check("glitch_mid_valid", 32'(valid_a), 32'd0);
    check("glitch_mid_high",  32'(hc_a), 32'd0);
    check("glitch_mid_low",   32'(lc_a), 32'd0);
`else
    check("glitch_mid_valid", 32'(valid_a), 32'd1);
    check("glitch_mid_high",  32'(hc_a), 32'd4);
    check("glitch_mid_low",   32'(lc_a), 32'd2);
`endif
    run_a(1'b1, 1);
    run_a(1'b0, 10);
    run_a(1'b1, 5);
    check("glitch_end_valid", 32'(valid_a), 32'd1);
    check("glitch_end_low",   32'(lc_a), 32'd10);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    check("glitch_end_high", 32'(hc_a), 32'd10);
    check("glitch_end_ovr",  32'(overrun_a), 32'd0);
`else
    check("glitch_end_high", 32'(hc_a), 32'd4);
    check("glitch_end_ovr",  32'(overrun_a), 32'd1);
`endif

    // ---- WIDTH = 4 saturation: high 20, then short low
    run_b(1'b1, 20);
    run_b(1'b0, LOW_B);
    run_b(1'b1, PUB);
    check("sat_valid", 32'(valid_b), 32'd1);
    check("sat_high",  32'(hc_b), 32'd15);
    check("sat_low",   32'(lc_b), 32'(LOW_B));
    check("sat_flag",  32'(sat_b), 32'd1);
    run_b(1'b1, 5 - PUB);
    run_b(1'b0, 3);
    run_b(1'b1, PUB);
    check("unsat_high", 32'(hc_b), 32'd5);
    check("unsat_low",  32'(lc_b), 32'd3);
    check("unsat_flag", 32'(sat_b), 32'd0);
    check("unsat_ovr",  32'(overrun_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

Measures the high and low durations of an incoming PWM waveform in `clk` cycles and publishes each complete period as a (high, low) pair. It is the receive-side counterpart of the team's PWM generator: a waveform produced with high count H and low count L reads back as high_count = H, low_count = L. It sits at the FPGA boundary behind a synchronizer and feeds a register/readout interface through a sticky valid/ack handshake.

## Interface
- WIDTH, 16, width of both duration counters and outputs
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer (min 2)
- FILTER_LEN, 3, samples required to accept a level change (glitch filter only)

- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; one clock `clk`, reset is synchronous and active-high
- pwm_in  in  1  asynchronous PWM input
- ack  in  1  one-cycle pulse; clears `valid` and `overrun`
- high_count  out  WIDTH  cycles high in last complete period
- low_count  out  WIDTH  cycles low in last complete period
- valid  out  1  sticky; new pair available
- overrun  out  1  sticky; a pair was overwritten while `valid` = 1
- sat  out  1  published pair contains a saturated count
- busy  out  1  state is HIGH or LOW

## Operation
- Input path: pwm_in -> SYNC_STAGES flops -> `s` (filtered level if filter compiled in) -> edge detector on `s` vs. its 1-cycle delayed copy.
- FSM states: IDLE, HIGH, LOW. Reset -> IDLE.
  - IDLE: ignore levels; on rising edge of `s` -> HIGH, hcnt <= 1.
  - HIGH: hcnt increments each cycle `s` = 1; on falling edge -> LOW, lcnt <= 1.
  - LOW: lcnt increments each cycle `s` = 0; on rising edge -> publish, then HIGH with hcnt <= 1 (back-to-back periods, no gap).
- Publish: high_count <= hcnt, low_count <= lcnt, sat <= either counter saturated; if `valid` already 1 then overrun <= 1; valid <= 1.
- Saturation: counters stop at 2^WIDTH-1 and set an internal sat flag for that counter; state unchanged. A constant input therefore stays in HIGH or LOW indefinitely; no publish until the next rising edge.
- ack: clears `valid` and `overrun` in the following cycle. ack in the same cycle as a publish: publish wins (valid = 1, overrun not set, overrun cleared).
- Counts are clean integers; no arithmetic beyond increment with saturation.

## Timing
- Reset values: high_count = 0, low_count = 0, valid = 0, overrun = 0, sat = 0, busy = 0; synchronizer and filter flops cleared to 0 (a high input after reset therefore produces one rising edge, which is not a full period and is discarded).
- Edge latency: pwm_in change -> edge detected SYNC_STAGES+1 cycles later (plus FILTER_LEN-1 with filter).
- Publish: outputs and `valid` update on the clock edge following the rising-edge detection cycle; same latency for every period, so durations are exact.
- First period after reset or IDLE is measured from the first rising edge; the leading partial high phase is never published.
- Minimum measurable phase: 1 cycle (no filter); FILTER_LEN cycles (with filter).
- rst mid-measurement: aborts to IDLE within one cycle, outputs return to reset values; a partial period is never published.

## Configuration
- PWM_CAPTURE_GLITCH_FILTER_EN defined: `s` changes only after FILTER_LEN consecutive identical synchronized samples differing from current `s`; pulses shorter than FILTER_LEN cycles are dropped entirely and counted as part of the surrounding phase; all edges delayed by FILTER_LEN-1 cycles (durations unchanged).
- Not defined: `s` is the raw synchronizer output; FILTER_LEN unused; every 1-cycle pulse is measured.

## Test plan
- Periodic input high 5 / low 3 cycles, no filter: after second rising edge valid = 1, high_count = 5, low_count = 3, sat = 0; repeats each 8 cycles.
- Two periods published without ack: overrun = 1, outputs show second pair; ack pulse -> valid = 0, overrun = 0 next cycle.
- WIDTH = 4, high held 20 cycles then low 2: published high_count = 15, low_count = 2, sat = 1.
- rst asserted during HIGH phase of a 10/10 waveform: next cycle busy = 0, valid = 0, counts 0; first publish occurs only after a full period following reset.
- With PWM_CAPTURE_GLITCH_FILTER_EN, FILTER_LEN = 3: high 10 / low 10 with a 2-cycle low glitch inside the high phase -> high_count = 10, low_count = 10; same stimulus without macro -> glitch publishes as separate short periods.
- ack coincident with publish: valid = 1, overrun = 0 after that cycle.
